// File: rtl/calc_engine_param.sv
// Calculator engine: debounced push-button launches one arithmetic op.
// MUL/DIV/MOD iterate WIDTH cycles; the other ops finish in a single cycle.
module calc_engine_param #(
  parameter int WIDTH   = 8,
  parameter int DEB_CNT = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 button,
  input  logic [2:0]           func,
  input  logic [WIDTH-1:0]     num1,
  input  logic [WIDTH-1:0]     num2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   cal_result,
  output logic                 flag_neg,
  output logic                 flag_error
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(DEB_CNT);
  localparam int IW = $clog2(WIDTH);

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_MUL = 3'd2;
  localparam logic [2:0] F_DIV = 3'd3;
  localparam logic [2:0] F_MOD = 3'd4;
  localparam logic [2:0] F_AND = 3'd5;
  localparam logic [2:0] F_OR  = 3'd6;
  localparam logic [2:0] F_ACC = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic          sync1, sync2;
  logic          deb;
  logic [CW-1:0] deb_cnt;
  logic          deb_hit;
  logic          press;

  assign deb_hit = (sync2 != deb) && (deb_cnt == CW'(DEB_CNT - 1));
  assign press   = deb_hit && sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      deb     <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      if (sync2 == deb) begin
        deb_cnt <= '0;
      end else if (deb_hit) begin
        deb     <= ~deb;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  logic             is_iter;
  logic [2:0]       op;
  logic [IW-1:0]    iter;
  logic             last_iter;
  logic [RW-1:0]    prod, prod_nx;
  logic [RW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] rem, rem_nx;
  logic [WIDTH-1:0] quo, quo_nx;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] trial_sub;
  logic             trial_ge;
  logic [RW-1:0]    fin_res;

  assign is_iter = (func == F_MUL) ||
                   (((func == F_DIV) || (func == F_MOD)) && (num2 != '0));
  assign last_iter = (iter == IW'(WIDTH - 1));

  // One restoring-division step and one shift-add step per CALC cycle
  always_comb begin
    trial     = {rem, quo[WIDTH-1]};
    trial_ge  = trial >= {1'b0, dvs};
    trial_sub = trial[WIDTH-1:0] - dvs;
    rem_nx    = trial_ge ? trial_sub : trial[WIDTH-1:0];
    quo_nx    = {quo[WIDTH-2:0], trial_ge};
    prod_nx   = mplier[0] ? prod + mcand : prod;
    if (op == F_MUL)
      fin_res = prod_nx;
    else if (op == F_DIV)
      fin_res = {{WIDTH{1'b0}}, quo_nx};
    else
      fin_res = {{WIDTH{1'b0}}, rem_nx};
  end

  logic [RW-1:0] sres;
  logic          sneg;
  logic          serr;
  logic [RW:0]   acc_sum;

  always_comb begin
    sres    = '0;
    sneg    = 1'b0;
    serr    = 1'b0;
    acc_sum = {1'b0, cal_result} + {{(WIDTH + 1){1'b0}}, num2};
    case (func)
      F_ADD: sres = {{WIDTH{1'b0}}, num1} + {{WIDTH{1'b0}}, num2};
      F_SUB: begin
        if (num1 >= num2) begin
          sres = {{WIDTH{1'b0}}, num1 - num2};
        end else begin
          sres = {{WIDTH{1'b0}}, num2 - num1};
          sneg = 1'b1;
        end
      end
      F_AND: sres = {{WIDTH{1'b0}}, num1 & num2};
      F_OR:  sres = {{WIDTH{1'b0}}, num1 | num2};
      F_ACC: begin
        if (flag_neg || flag_error) begin
          serr = 1'b1;
        end else begin
          sres = acc_sum[RW-1:0];
          serr = acc_sum[RW];
        end
      end
      // Only a zero divisor reaches here as a single-cycle op
      default: serr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (press) state_nx = is_iter ? S_CALC : S_DONE;
      end
      S_CALC: begin
        if (last_iter) state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op         <= F_ADD;
      iter       <= '0;
      prod       <= '0;
      mcand      <= '0;
      mplier     <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      cal_result <= '0;
      flag_neg   <= 1'b0;
      flag_error <= 1'b0;
    end else if (state == S_IDLE && press) begin
      op     <= func;
      iter   <= '0;
      prod   <= '0;
      mcand  <= {{WIDTH{1'b0}}, num1};
      mplier <= num2;
      rem    <= '0;
      quo    <= num1;
      dvs    <= num2;
      if (!is_iter) begin
        cal_result <= sres;
        flag_neg   <= sneg;
        flag_error <= serr;
      end
    end else if (state == S_CALC) begin
      iter   <= iter + 1'b1;
      prod   <= prod_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      rem    <= rem_nx;
      quo    <= quo_nx;
      if (last_iter) begin
        cal_result <= fin_res;
        flag_neg   <= 1'b0;
        flag_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc_engine_param.sv
// Bench for calc_engine_param: cycle model of button/op timing,
// results from plain integer arithmetic, plus literal spot checks.
module tb_calc_engine_param;

  localparam int W   = 8;
  localparam int DEB = 4;
  localparam int RW  = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          button;
  logic [2:0]    func;
  logic [W-1:0]  num1, num2;
  logic          busy, done, flag_neg, flag_error;
  logic [RW-1:0] cal_result;

  calc_engine_param #(.WIDTH(W), .DEB_CNT(DEB)) dut (
    .clk(clk), .rst(rst), .button(button), .func(func),
    .num1(num1), .num2(num2), .busy(busy), .done(done),
    .cal_result(cal_result), .flag_neg(flag_neg),
    .flag_error(flag_error)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int fails = 0;
  int ndone = 0;
  longint cyc = 0;
  longint t_press = -1;
  longint done_cyc = -1;
  bit en = 0;

  // model state
  bit s1, s2, deb_lvl;
  int run;
  int left;
  bit m_busy, m_done, m_neg, m_err;
  logic [RW-1:0] m_res;
  logic [RW-1:0] p_res;
  bit p_neg, p_err;

  function automatic void calc(input int f, input longint a, input longint b,
                               input longint pr, input bit pn, input bit pe,
                               output longint r, output bit n, output bit e);
    longint s;
    r = 0; n = 0; e = 0;
    case (f)
      0: r = a + b;
      1: if (a >= b) r = a - b; else begin r = b - a; n = 1; end
      2: r = a * b;
      3: if (b == 0) e = 1; else r = a / b;
      4: if (b == 0) e = 1; else r = a % b;
      5: r = a & b;
      6: r = a | b;
      default: begin
        if (pn || pe) e = 1;
        else begin
          s = pr + b;
          if (s >= (longint'(1) << RW)) e = 1;
          r = s % (longint'(1) << RW);
        end
      end
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    longint r;
    bit n, e, press, was_done;
    if (!rst) begin
      s1 = 0; s2 = 0; deb_lvl = 0; run = 0; left = 0;
      m_busy = 0; m_done = 0; m_res = '0; m_neg = 0; m_err = 0;
    end else begin
      cyc++;
      press = 0;
      if (s2 != deb_lvl) begin
        run++;
        if (run == DEB) begin
          deb_lvl = s2; run = 0; press = s2;
        end
      end else run = 0;
      s2 = s1;
      s1 = button;
      was_done = m_done;
      m_done = 0;
      if (left > 0) begin
        left--;
        if (left == 0) begin
          m_res = p_res; m_neg = p_neg; m_err = p_err; m_done = 1;
        end
      end else if (!was_done && press) begin
        t_press = cyc - 1;
        calc(func, num1, num2, m_res, m_neg, m_err, r, n, e);
        if (func == 2 || ((func == 3 || func == 4) && num2 != 0)) begin
          left = W;
          p_res = RW'(r); p_neg = n; p_err = e;
        end else begin
          m_res = RW'(r); m_neg = n; m_err = e; m_done = 1;
        end
      end
      m_busy = (left > 0);
    end
  end

  always @(negedge clk) begin
    if (rst && en) begin
      vecs++;
      if (done) begin ndone++; done_cyc = cyc; end
      if (busy !== m_busy || done !== m_done || cal_result !== m_res ||
          flag_neg !== m_neg || flag_error !== m_err) begin
        fails++;
        $display("FAIL cycle %0d: dut busy=%b done=%b res=%0d neg=%b err=%b, model busy=%b done=%b res=%0d neg=%b err=%b",
                 cyc, busy, done, cal_result, flag_neg, flag_error,
                 m_busy, m_done, m_res, m_neg, m_err);
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    vecs++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic hold(input bit v, input int n);
    button = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic op(input int f, input int a, input int b);
    func = 3'(f); num1 = W'(a); num2 = W'(b);
    hold(1, DEB + 2);
    button = 0;
    func = 3'($urandom); num1 = W'($urandom); num2 = W'($urandom);
    repeat (W + DEB + 8) @(negedge clk);
  endtask

  initial begin
    int d0;
    int k;
    rst = 0; button = 0; func = 0; num1 = 0; num2 = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset result", cal_result, 0);
    chk("reset neg", flag_neg, 0);
    chk("reset error", flag_error, 0);
    rst = 1; en = 1;
    @(negedge clk);

    d0 = ndone;
    op(0, 200, 100);
    chk("add result", cal_result, 300);
    chk("add latency", done_cyc - t_press, 1);
    chk("add dones", ndone - d0, 1);

    op(1, 5, 9);
    chk("sub result", cal_result, 4);
    chk("sub neg", flag_neg, 1);
    op(7, 0, 1);
    chk("acc after neg result", cal_result, 0);
    chk("acc after neg error", flag_error, 1);

    // second press lands while the multiply is still running
    d0 = ndone;
    func = 3'd2; num1 = 8'd255; num2 = 8'd255;
    hold(1, DEB); hold(0, DEB);
    func = 3'd0; num1 = 8'd1; num2 = 8'd1;
    hold(1, DEB); hold(0, W + DEB + 8);
    chk("mul dones", ndone - d0, 1);
    chk("mul result", cal_result, 65025);
    chk("mul latency", done_cyc - t_press, W + 1);

    op(7, 0, 255);
    op(7, 0, 255);
    chk("acc to max", cal_result, 65535);
    op(7, 0, 1);
    chk("acc wrap result", cal_result, 0);
    chk("acc wrap error", flag_error, 1);

    op(3, 200, 7);
    chk("div result", cal_result, 28);
    chk("div latency", done_cyc - t_press, W + 1);
    op(4, 200, 7);
    chk("mod result", cal_result, 4);
    op(3, 9, 0);
    chk("div0 result", cal_result, 0);
    chk("div0 error", flag_error, 1);
    chk("div0 latency", done_cyc - t_press, 1);

    d0 = ndone;
    func = 3'd0; num1 = 8'd1; num2 = 8'd2;
    hold(1, 1); hold(0, 1); hold(1, 2); hold(0, 1); hold(1, 5);
    hold(1, 4); hold(0, 20);
    chk("bounce dones", ndone - d0, 1);
    chk("bounce result", cal_result, 3);
    d0 = ndone;
    hold(1, 3); hold(0, 20);
    chk("glitch dones", ndone - d0, 0);

    // reset in the middle of a multiply
    func = 3'd2; num1 = 8'd13; num2 = 8'd11;
    button = 1;
    k = 0;
    while (left != W - 3 && k < 50) begin
      @(negedge clk); k++;
    end
    chk("reach mul T+4", k < 50, 1);
    #2 rst = 0; button = 0;
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", cal_result, 0);
    chk("rst error", flag_error, 0);
    repeat (3) @(negedge clk);
    rst = 1;
    d0 = ndone;
    repeat (30) @(negedge clk);
    chk("rst no done", ndone - d0, 0);

    // button held high across reset release
    func = 3'd6; num1 = 8'h0f; num2 = 8'hf0;
    button = 1;
    @(negedge clk);
    #2 rst = 0;
    repeat (2) @(negedge clk);
    rst = 1;
    d0 = ndone;
    repeat (DEB + 6) @(negedge clk);
    button = 0;
    repeat (DEB + 6) @(negedge clk);
    chk("held press dones", ndone - d0, 1);
    chk("held press result", cal_result, 255);

    for (int i = 0; i < 60; i++) begin
      func = 3'($urandom);
      num1 = W'($urandom);
      num2 = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      hold(1, $urandom_range(1, DEB + 4));
      func = 3'($urandom); num1 = W'($urandom); num2 = W'($urandom);
      hold(0, $urandom_range(1, DEB + 4));
      if ($urandom_range(0, 3) == 0) repeat (W + 2) @(negedge clk);
    end
    repeat (W + DEB + 8) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/calc_engine_param.md
# calc_engine_param

Parametrised calculator engine for the board-level calculator designs. It takes a raw push-button, a 3-bit function code and two WIDTH-bit operands, and debounces the button. On each accepted press it computes one result, either in a single cycle or iteratively in WIDTH cycles. It presents the result, sign and error flags to the display block, and replaces the fixed 8-bit calculator core, adding multiply/divide/modulo and an accumulate mode.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥2); result width RW = 2*WIDTH (localparam).
- DEB_CNT, 1000000, number of consecutive stable synchronised samples needed to change the debounced button level (≥2).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- button  in  1  raw asynchronous push-button, active-high.
- func  in  3  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5 AND, 6 OR, 7 ACC.
- num1  in  WIDTH  operand A, unsigned.
- num2  in  WIDTH  operand B, unsigned.
- busy  out  1  high while an iterative operation is running.
- done  out  1  one-cycle pulse when cal_result/flags update.
- cal_result  out  RW  result magnitude, unsigned.
- flag_neg  out  1  result is negative; magnitude is in cal_result.
- flag_error  out  1  last operation was invalid or overflowed.

## Operation
- Button path:
  - 2-flop synchroniser.
  - Counter increments each cycle the synchronised level differs from the debounced level, and clears on any matching cycle.
  - When the counter reaches DEB_CNT-1, the debounced level toggles and the counter clears.
  - A press is the cycle the debounced level goes 0→1 (cycle T).
- A press is accepted only in IDLE; presses while busy are dropped, not queued. On acceptance, func, num1 and num2 are captured at T. Later input changes do not affect the running operation.
- FSM states: IDLE, CALC, DONE.
  - IDLE→DONE on an accepted single-cycle op (ADD, SUB, AND, OR, ACC, and DIV/MOD with num2=0).
  - IDLE→CALC on MUL, or on DIV/MOD with num2≠0.
  - CALC→DONE after exactly WIDTH iterations.
  - DONE→IDLE unconditionally.
- Arithmetic:
  - ADD: zero-extended A+B.
  - SUB: if A≥B, result A−B with flag_neg=0; else B−A with flag_neg=1.
  - AND/OR: bitwise, zero-extended.
  - MUL: shift-add over WIDTH iterations, exact 2*WIDTH-bit product.
  - DIV/MOD: restoring division over WIDTH iterations, quotient or remainder.
  - Divisor 0: cal_result=0, flag_error=1.
  - ACC: previous cal_result + B over RW bits.
    - Carry out of RW: flag_error=1, wrapped sum kept.
    - If previous flag_neg=1 or previous flag_error=1: cal_result=0, flag_error=1.
- In DONE, cal_result/flag_neg/flag_error load together and hold until the next DONE. flag_neg=0 whenever flag_error=1. flag_neg and flag_error are both 0 for all ops other than those above.
- Reset values: state IDLE; busy=0, done=0, cal_result=0, flag_neg=0, flag_error=0; synchroniser, debounced level and counter 0.

## Timing
- Button-to-T: 2 synchroniser cycles + DEB_CNT stable cycles.
- Single-cycle ops: done=1 and new outputs at T+1; busy stays 0.
- Iterative ops: busy=1 during T+1..T+WIDTH; done=1 with new outputs at T+WIDTH+1, busy=0 that cycle. Next press is accepted from T+WIDTH+2.
- Reset asserted mid-operation: immediate return to reset values; no done; the partial result is discarded.
- Button held high across reset release: counts as a fresh press once DEB_CNT stable samples elapse.
- Glitch shorter than DEB_CNT samples: no press.

## Test plan
- Run with WIDTH=8, DEB_CNT=4.
- ADD 200+100, clean press → done at T+1, cal_result=300, flags 0, busy never high.
- SUB 5−9 → cal_result=4, flag_neg=1; then ACC with num2=1 → cal_result=0, flag_error=1.
- MUL 255×255 → busy for 8 cycles, done at T+9, cal_result=65025. A second press mid-run is ignored (exactly one done).
- DIV 200/7 → 28; MOD 200/7 → 4 (each done at T+9). DIV 9/0 → done at T+1, cal_result=0, flag_error=1.
- Bounce pattern 1,0,1,1,0,1,1,1,1,1 on button → exactly one press; 3-cycle pulse → none.
- Assert rst during MUL cycle T+4 → all outputs 0 immediately; no done after release. ACC 65535+1 from cal_result=65535 → cal_result=0, flag_error=1.
